sys_ctrl_seq: RTL and testbench

SYS_CTRL_SEQ -- requirements
Module: sys_ctrl_seq

---
 rtl/sys_ctrl_seq.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_sys_ctrl_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_seq.sv
// -----------------------------------------------------------------------------
// sys_ctrl_seq
//   Register-programmed sequencer for a PE array. A START write kicks off one
//   sequence: a single accumulator-clear cycle, (max_cntr+1)*run_cntr run
//   cycles stepping the buffer read index, DRAIN_CYC pipeline-drain cycles,
//   then a sticky done flag (and optionally an interrupt).
//
//   Optional feature macro: SYS_CTRL_IRQ_EN
//     defined   -> irq flop set on completion, cleared by any IRQ_CLR write,
//                  IRQ_CLR readable as {15'b0, irq}
//     undefined -> irq tied to 0, IRQ_CLR not decoded
//
// Parameters
//   ADR_BASE   base address of the four control registers
//   DRAIN_CYC  drain cycles after the last run cycle (1..15)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   ren, ibus_radr         read strobe / address
//   wen, ibus_wadr,
//   ibus_wdata             write strobe / address / data
//   ibus_rdata, rdata_hit  registered read data, valid-for-this-block flag
//   pe_clr, pe_en          PE accumulator clear / PE+buffer advance
//   cntr                   inner step count (buffer read index)
//   busy                   sequence active (CLEAR, RUN, DRAIN)
//   irq                    completion interrupt
//
// Register map (offset from ADR_BASE)
//   +0 START    W: [0]=start (idle/done only), [1]=clear done
//               R: {14'b0, done, busy}
//   +1 MAX_CNTR R/W, writable only while not busy
//   +2 RUN_CNTR R/W, writable only while not busy
//   +3 IRQ_CLR  W: any write clears irq; R: {15'b0, irq}
// -----------------------------------------------------------------------------
module sys_ctrl_seq #(
    parameter logic [15:0] ADR_BASE  = 16'hFFF0,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ren,
    input  logic [15:0] ibus_radr,
    input  logic        wen,
    input  logic [15:0] ibus_wadr,
    input  logic [15:0] ibus_wdata,
    output logic [15:0] ibus_rdata,
    output logic        rdata_hit,
    output logic        pe_clr,
    output logic        pe_en,
    output logic [15:0] cntr,
    output logic        busy,
    output logic        irq
);

    localparam logic [15:0] ADR_START = ADR_BASE;
    localparam logic [15:0] ADR_MAX   = ADR_BASE + 16'd1;
    localparam logic [15:0] ADR_RUN   = ADR_BASE + 16'd2;
`ifdef SYS_CTRL_IRQ_EN
    localparam logic [15:0] ADR_IRQ   = ADR_BASE + 16'd3;
`endif
    localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [15:0] max_cntr;
    logic [15:0] run_cntr;
    logic [15:0] iter;
    logic [3:0]  drain_cnt;
    logic        done;

    logic        wr_start;
    logic        wr_max;
    logic        wr_run;
    logic        start_go;
    logic        run_last;
    logic        drain_last;
    logic        enter_done;

    logic        rd_hit_nx;
    logic [15:0] rd_data_nx;

    // ---------------------------------------------------------------- decode
    always_comb begin
        wr_start   = wen && (ibus_wadr == ADR_START);
        wr_max     = wen && (ibus_wadr == ADR_MAX);
        wr_run     = wen && (ibus_wadr == ADR_RUN);
        start_go   = wr_start && ibus_wdata[0] &&
                     ((state == IDLE) || (state == DONE));
        // Final run cycle: last step of the last iteration. run_cntr==0 never
        // reaches RUN, so the subtraction cannot underflow in use.
        run_last   = (cntr == max_cntr) && (iter == (run_cntr - 16'd1));
        drain_last = (drain_cnt == DRAIN_LAST);
        enter_done = (state_nx == DONE) && (state != DONE);
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start_go) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                state_nx = (run_cntr != 16'd0) ? RUN : DONE;
            end
            RUN: begin
                if (run_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_nx = DONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------------- outputs
    always_comb begin
        pe_clr = 1'b0;
        pe_en  = 1'b0;
        busy   = 1'b0;
        case (state)
            CLEAR: begin
                pe_clr = 1'b1;
                busy   = 1'b1;
            end
            RUN, DRAIN: begin
                pe_en  = 1'b1;
                busy   = 1'b1;
            end
            default: begin
                pe_clr = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------ config registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_cntr <= '0;
            run_cntr <= '0;
        end else if (!busy) begin
            if (wr_max) begin
                max_cntr <= ibus_wdata;
            end
            if (wr_run) begin
                run_cntr <= ibus_wdata;
            end
        end
    end

    // ------------------------------------------------- step / iteration counters
    // Counters are zeroed on the accepted start so they already read 0 during
    // the CLEAR cycle. DRAIN holds cntr at whatever the last RUN step left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr      <= '0;
            iter      <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_go) begin
                        cntr <= '0;
                        iter <= '0;
                    end
                end
                CLEAR: begin
                    drain_cnt <= '0;
                end
                RUN: begin
                    if (cntr == max_cntr) begin
                        cntr <= '0;
                        iter <= iter + 16'd1;
                    end else begin
                        cntr <= cntr + 16'd1;
                    end
                end
                DRAIN: begin
                    if (!drain_last) begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: begin
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (enter_done) begin
            done <= 1'b1;
        end else if (start_go || (wr_start && ibus_wdata[1])) begin
            done <= 1'b0;
        end
    end

    // --------------------------------------------------------------- interrupt
`ifdef SYS_CTRL_IRQ_EN
    logic irq_q;
    logic wr_irq;

    assign wr_irq = wen && (ibus_wadr == ADR_IRQ);

    // Completion wins over a same-cycle IRQ_CLR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (enter_done) begin
            irq_q <= 1'b1;
        end else if (wr_irq) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // --------------------------------------------------------------- read path
    // Read data is captured from the current register values on the same edge
    // that may write them, so a same-cycle read returns the pre-write value.
    always_comb begin
        rd_hit_nx  = 1'b0;
        rd_data_nx = '0;
        if (ren) begin
            case (ibus_radr)
                ADR_START: begin
                    rd_hit_nx  = 1'b1;
                    rd_data_nx = {14'b0, done, busy};
                end
                ADR_MAX: begin
                    rd_hit_nx  = 1'b1;
                    rd_data_nx = max_cntr;
                end
                ADR_RUN: begin
                    rd_hit_nx  = 1'b1;
                    rd_data_nx = run_cntr;
                end
`ifdef SYS_CTRL_IRQ_EN
                ADR_IRQ: begin
                    rd_hit_nx  = 1'b1;
                    rd_data_nx = {15'b0, irq_q};
                end
`endif
                default: begin
                    rd_hit_nx  = 1'b0;
                    rd_data_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_hit  <= 1'b0;
            ibus_rdata <= '0;
        end else begin
            rdata_hit  <= rd_hit_nx;
            ibus_rdata <= rd_data_nx;
        end
    end

endmodule

// File: tb/tb_sys_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl_seq
//   Directed bench for sys_ctrl_seq. Register reads are checked by a
//   scoreboard: each read pushes its expected {hit, data} into a queue and a
//   monitor pops and compares one cycle after every ren. Sequencer behaviour
//   is checked from per-cycle samples of pe_clr / pe_en / busy / cntr.
//   Compile with +define+SYS_CTRL_IRQ_EN to exercise the interrupt build.
// -----------------------------------------------------------------------------
module tb_sys_ctrl_seq;

    localparam logic [15:0] A_START = 16'hFFF0;
    localparam logic [15:0] A_MAX   = 16'hFFF1;
    localparam logic [15:0] A_RUN   = 16'hFFF2;
    localparam logic [15:0] A_IRQ   = 16'hFFF3;

    logic        clk;
    logic        rst_n;
    logic        ren;
    logic [15:0] ibus_radr;
    logic        wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus_wdata;
    logic [15:0] ibus_rdata;
    logic        rdata_hit;
    logic        pe_clr;
    logic        pe_en;
    logic [15:0] cntr;
    logic        busy;
    logic        irq;

    int          checks   = 0;
    int          failures = 0;

    logic [16:0] exp_q[$];

    logic        s_clr [64];
    logic        s_en  [64];
    logic        s_busy[64];
    logic [15:0] s_cntr[64];

    sys_ctrl_seq #(
        .ADR_BASE (16'hFFF0),
        .DRAIN_CYC(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ren       (ren),
        .ibus_radr (ibus_radr),
        .wen       (wen),
        .ibus_wadr (ibus_wadr),
        .ibus_wdata(ibus_wdata),
        .ibus_rdata(ibus_rdata),
        .rdata_hit (rdata_hit),
        .pe_clr    (pe_clr),
        .pe_en     (pe_en),
        .cntr      (cntr),
        .busy      (busy),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- monitor
    initial begin
        logic        pend;
        logic [16:0] e;
        forever begin
            @(posedge clk);
            pend = ren;
            #1;
            checks++;
            if (pend) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL read_noexp got hit=%b data=%h, no expectation queued",
                             rdata_hit, ibus_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rdata_hit, ibus_rdata} !== e) begin
                        failures++;
                        $display("FAIL read got hit=%b data=%h expected hit=%b data=%h",
                                 rdata_hit, ibus_rdata, e[16], e[15:0]);
                    end
                end
            end else if (rdata_hit !== 1'b0 || ibus_rdata !== 16'h0000) begin
                failures++;
                $display("FAIL read_idle got hit=%b data=%h expected hit=0 data=0000",
                         rdata_hit, ibus_rdata);
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] adr, input logic [15:0] data);
        @(negedge clk);
        wen = 1'b1; ibus_wadr = adr; ibus_wdata = data;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] adr, input logic hit, input logic [15:0] data);
        @(negedge clk);
        ren = 1'b1; ibus_radr = adr;
        exp_q.push_back({hit, data});
        @(negedge clk);
        ren = 1'b0;
    endtask

    // Optionally issue a START (wdata=sdata), then sample n cycles at edge+1.
    // inj >= 0 injects a MAX_CNTR=7 write then a START write at that sample.
    task automatic watch(input bit do_start, input logic [15:0] sdata, input int n, input int inj);
        if (do_start) begin
            @(negedge clk);
            wen = 1'b1; ibus_wadr = A_START; ibus_wdata = sdata;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_clr[i]  = pe_clr;
            s_en[i]   = pe_en;
            s_busy[i] = busy;
            s_cntr[i] = cntr;
            wen = 1'b0;
            if (inj >= 0 && i == inj) begin
                wen = 1'b1; ibus_wadr = A_MAX; ibus_wdata = 16'h0007;
            end
            if (inj >= 0 && i == inj + 1) begin
                wen = 1'b1; ibus_wadr = A_START; ibus_wdata = 16'h0001;
            end
        end
        wen = 1'b0;
    endtask

    task automatic count(input int n, output int nclr, output int nen, output int nbusy);
        nclr = 0; nen = 0; nbusy = 0;
        for (int i = 0; i < n; i++) begin
            nclr  += int'(s_clr[i]);
            nen   += int'(s_en[i]);
            nbusy += int'(s_busy[i]);
        end
    endtask

    // Checks a full MAX=3 / RUN=4 sequence captured by watch(...,30,...).
    task automatic check_full_seq(input string tag);
        int nclr, nen, nbusy, bad;
        count(30, nclr, nen, nbusy);
        chk({tag, "_pe_clr_cycles"}, 16'(nclr), 16'd1);
        chk({tag, "_pe_en_cycles"},  16'(nen),  16'd20);
        chk({tag, "_busy_cycles"},   16'(nbusy), 16'd21);
        chk({tag, "_clear_first"},   {15'b0, s_clr[0]}, 16'd1);
        chk({tag, "_clear_cntr"},    s_cntr[0], 16'd0);
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (s_cntr[i] !== 16'((i - 1) % 4) || s_en[i] !== 1'b1) bad++;
        end
        chk({tag, "_run_cntr_pattern_errs"}, 16'(bad), 16'd0);
        chk({tag, "_busy_after"}, {15'b0, s_busy[21]}, 16'd0);
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        int nclr, nen, nbusy;
        rst_n = 1'b0; ren = 1'b0; wen = 1'b0;
        ibus_radr = '0; ibus_wadr = '0; ibus_wdata = '0;
        #1;
        chk("reset_busy",  {15'b0, busy}, 16'd0);
        chk("reset_pe_en", {15'b0, pe_en}, 16'd0);
        chk("reset_cntr",  cntr, 16'd0);
        chk("reset_irq",   {15'b0, irq}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        rd(A_START, 1'b1, 16'h0000);
        rd(A_MAX,   1'b1, 16'h0000);
        rd(16'h1234, 1'b0, 16'h0000);

        wr(A_MAX, 16'd3);
        wr(A_RUN, 16'd4);
        rd(A_RUN, 1'b1, 16'h0004);
        rd(A_MAX, 1'b1, 16'h0003);

        // Full sequence, START=ffff also exercises the done-clear bit.
        watch(1'b1, 16'hFFFF, 30, -1);
        check_full_seq("seq1");
        rd(A_START, 1'b1, 16'h0002);
`ifdef SYS_CTRL_IRQ_EN
        chk("irq_after_done", {15'b0, irq}, 16'd1);
        rd(A_IRQ, 1'b1, 16'h0001);
        wr(A_IRQ, 16'h0000);
        chk("irq_after_clr", {15'b0, irq}, 16'd0);
        rd(A_IRQ, 1'b1, 16'h0000);
`else
        chk("irq_tied_low", {15'b0, irq}, 16'd0);
        rd(A_IRQ, 1'b0, 16'h0000);
`endif

        // Clear done without starting.
        wr(A_START, 16'h0002);
        rd(A_START, 1'b1, 16'h0000);

        // Writes during RUN are dropped.
        watch(1'b1, 16'h0001, 30, 5);
        check_full_seq("seq2");
        rd(A_MAX,   1'b1, 16'h0003);
        rd(A_START, 1'b1, 16'h0002);

        // Same-cycle read and write of MAX_CNTR returns the old value.
        @(negedge clk);
        ren = 1'b1; ibus_radr = A_MAX;
        wen = 1'b1; ibus_wadr = A_MAX; ibus_wdata = 16'd9;
        exp_q.push_back({1'b1, 16'h0003});
        @(negedge clk);
        ren = 1'b0; wen = 1'b0;
        rd(A_MAX, 1'b1, 16'h0009);

        // RUN_CNTR=0: one clear cycle, no run.
        wr(A_RUN, 16'd0);
        watch(1'b1, 16'h0001, 4, -1);
        count(4, nclr, nen, nbusy);
        chk("zero_run_pe_clr", 16'(nclr), 16'd1);
        chk("zero_run_pe_en",  16'(nen),  16'd0);
        chk("zero_run_busy",   16'(nbusy), 16'd1);
        rd(A_START, 1'b1, 16'h0002);

        // Reset in the middle of RUN.
        wr(A_RUN, 16'd4);
        watch(1'b1, 16'h0001, 6, -1);
        chk("pre_reset_running", {15'b0, s_en[5]}, 16'd1);
        chk("pre_reset_cntr",    s_cntr[5], 16'd4);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy",   {15'b0, busy},   16'd0);
        chk("midreset_pe_en",  {15'b0, pe_en},  16'd0);
        chk("midreset_pe_clr", {15'b0, pe_clr}, 16'd0);
        chk("midreset_cntr",   cntr, 16'd0);
        chk("midreset_irq",    {15'b0, irq}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(1'b0, 16'h0000, 10, -1);
        count(10, nclr, nen, nbusy);
        chk("post_reset_busy",  16'(nbusy), 16'd0);
        chk("post_reset_pe_en", 16'(nen),   16'd0);
        rd(A_RUN,   1'b1, 16'h0000);
        rd(A_START, 1'b1, 16'h0000);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
